// File: rtl/tt_10_ef6404_nand.sv
// Registered 8-bit bitwise NAND of ui_in and uio_in with a synchronous active-high reset on rst_n.
// Optional macro NAND_ENA_GATE_EN: when defined, the result register loads only while ena=1.
module tt_10_ef6404_nand (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] uo_out_q, uo_out_d;
  logic       load;

`ifdef NAND_ENA_GATE_EN
  assign load = ena;
`else
  // ena only matters in the gated build; free-running otherwise.
  logic unused_ena;
  assign unused_ena = ena;
  assign load       = 1'b1;
`endif

  always_comb begin
    uo_out_d = uo_out_q;
    if (rst_n) begin
      uo_out_d = 8'h00;
    end else if (load) begin
      uo_out_d = ~(ui_in & uio_in);
    end
  end

  always_ff @(posedge clk) begin
    uo_out_q <= uo_out_d;
  end

  assign uo_out  = uo_out_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_10_ef6404_nand.sv
// Bench for tt_10_ef6404_nand: directed boundary cases plus random stimulus against a model.
module tb_tt_10_ef6404_nand;

`ifdef NAND_ENA_GATE_EN
  localparam bit Gated = 1'b1;
`else
  localparam bit Gated = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_val;
  bit         model_valid = 1'b0;

  tt_10_ef6404_nand dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Model: result is all-ones minus the AND of the operands; reset wins, gate may hold.
  always @(posedge clk) begin
    if (rst_n) begin
      model_val   <= 8'h00;
      model_valid <= 1'b1;
    end else if (!Gated || ena) begin
      model_val <= 8'hFF - (ui_in & uio_in);
    end
  end

  // Per-cycle compare, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (model_valid) begin
      vectors++;
      if (uo_out !== model_val || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        miscompares++;
        $display("FAIL model t=%0t: uo_out=%h uio_out=%h uio_oe=%h, required %h/00/00",
                 $time, uo_out, uio_out, uio_oe, model_val);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = a;
    uio_in = b;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two edges
    drive(1'b1, 1'b1, 8'h0F, 8'h33);
    edge1();
    edge1();
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);

    drive(1'b0, 1'b1, 8'hF0, 8'hCC);
    edge1();
    check("basic_nand", uo_out, 8'h3F);

    // Operand change between edges must not reach the output early
    ui_in = 8'h00;
    #3;
    check("latency_hold", uo_out, 8'h3F);
    edge1();
    check("latency_update", uo_out, 8'hFF);

    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    edge1();
    check("all_ones", uo_out, 8'h00);
    drive(1'b0, 1'b1, 8'h00, 8'hA5);
    edge1();
    check("zero_operand", uo_out, 8'hFF);

    drive(1'b0, 1'b1, 8'hF0, 8'hCC);
    edge1();
    check("enable_load", uo_out, 8'h3F);
    drive(1'b0, 1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      edge1();
      check("enable_low", uo_out, Gated ? 8'h3F : 8'h00);
    end
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    edge1();
    check("enable_high", uo_out, 8'h00);

    // Reset asserted between edges must wait for the edge
    drive(1'b0, 1'b1, 8'h0F, 8'hF0);
    edge1();
    check("pre_reset", uo_out, 8'hFF);
    rst_n = 1'b1;
    #2;
    check("no_async_reset", uo_out, 8'hFF);
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    edge1();
    check("reset_priority", uo_out, 8'h00);

    drive(1'b0, 1'b0, 8'h12, 8'h34);
    edge1();
    check("first_after_reset", uo_out, Gated ? 8'h00 : 8'hEF);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) == 0), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
